// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner, instruction memory request driver and fetch FIFO toward decode.
module instruction_fetch #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_address,
  output logic              imem_enable,
  output logic              imem_read,
  output logic [DATA_W-1:0] imem_data_in,
  input  logic [DATA_W-1:0] imem_data_out,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DL = (CW+1)'(DEPTH);
  logic [ADDR_W-1:0] pc, inflight_pc;
  logic [CW-1:0] cnt;
  logic [AW-1:0] rd, wr;
  logic inflight, kill, issue, push, pop;
  logic [DATA_W-1:0] dq [DEPTH];
  logic [ADDR_W-1:0] pq [DEPTH];
  // credit counts registered occupancy plus the outstanding response only
  assign issue = rst_n & fetch_en & ~redirect_valid & (({1'b0, cnt} + {{CW{1'b0}}, inflight}) < DL);
  assign push = inflight & ~kill & ~redirect_valid;
  assign inst_valid = cnt != '0;
  assign pop = inst_valid & inst_ready;
  assign imem_address = pc;
  assign imem_enable = issue;
  assign imem_read = issue;
  assign imem_data_in = '0;
  assign inst_data = inst_valid ? dq[rd] : '0;
  assign inst_pc = inst_valid ? pq[rd] : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      inflight_pc <= '0;
      cnt <= '0;
      rd <= '0;
      wr <= '0;
      inflight <= 1'b0;
      kill <= 1'b0;
    end else begin
      inflight <= issue;
      kill <= redirect_valid & inflight;
      if (issue) begin
        pc <= pc + PC_STEP;
        inflight_pc <= pc;
      end
      if (redirect_valid) begin
        pc <= redirect_pc;
        cnt <= '0;
        rd <= '0;
        wr <= '0;
      end else begin
        if (push) wr <= wr + AW'(1);
        if (pop) rd <= rd + AW'(1);
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      dq[wr] <= imem_data_out;
      pq[wr] <= inflight_pc;
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) push |-> (cnt < CW'(DEPTH) || pop));
endmodule
